// File: rtl/nr_alu_pkg.sv
// Shared opcodes, FSM encoding and overflow codes for nr_seq_alu.
package nr_alu_pkg;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_FTST = 2;
  localparam int unsigned OP_AND  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_SLT  = 6;
  localparam int unsigned OP_SHL  = 7;
  localparam int unsigned OP_SHR  = 8;
  localparam int unsigned OP_MUL  = 9;
  localparam int unsigned OP_DIV  = 10;
  localparam int unsigned OP_REM  = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OVF_NONE = 2'b00;
  localparam logic [1:0] OVF_POS  = 2'b01;
  localparam logic [1:0] OVF_NEG  = 2'b10;

endpackage

// File: rtl/nr_iter_muldiv.sv
// WIDTH-step shift-add multiplier, plus a restoring divider when NR_SEQ_ALU_DIV_EN is defined.
// nx_hi/nx_lo are the values after the current step; last is high on the final step.
module nr_iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef NR_SEQ_ALU_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nx_hi,
  output logic [WIDTH-1:0] nx_lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, b_q;
  logic [WIDTH:0]   add_w;
`ifdef NR_SEQ_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_w, sub_w;
`endif

  always_comb begin
    add_w = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    nx_hi = add_w[WIDTH:1];
    nx_lo = {add_w[0], lo[WIDTH-1:1]};
`ifdef NR_SEQ_ALU_DIV_EN
    // partial remainder never reaches 2*b, so bit WIDTH of sub_w is a clean borrow
    rem_w = {hi, lo[WIDTH-1]};
    sub_w = rem_w - {1'b0, b_q};
    if (div_q) begin
      nx_hi = sub_w[WIDTH] ? rem_w[WIDTH-1:0] : sub_w[WIDTH-1:0];
      nx_lo = {lo[WIDTH-2:0], ~sub_w[WIDTH]};
    end
`endif
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
`ifdef NR_SEQ_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
`ifdef NR_SEQ_ALU_DIV_EN
      div_q <= div;
`endif
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      hi  <= nx_hi;
      lo  <= nx_lo;
    end
  end

endmodule

// File: rtl/nr_seq_alu.sv
// Registered ALU with valid/ready handshake and iterative MUL (DIV/REM with NR_SEQ_ALU_DIV_EN).
// Handshake: a request is taken on a rising edge with in_valid && in_ready; a result is
// retired on a rising edge with out_valid && out_ready. in_ready is high only in IDLE.
module nr_seq_alu
  import nr_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             u_zero,
  output logic             carry,
  output logic [1:0]       ovrflw,
  output logic             neg,
  output logic             err
);

  state_t           state;
  logic             busy_div;
  logic [WIDTH:0]   sum, shl_w, shr_w;
  logic [WIDTH-1:0] diff, nx_result, nx_hi, md_hi, md_lo;
  logic             nx_carry, nx_zero, nx_err, nx_iter, nx_div, md_last, start;
  logic [1:0]       nx_ovf;

  assign in_ready = (state == S_IDLE) && !rst;
  assign start    = (state == S_IDLE) && in_valid && nx_iter;

  always_comb begin
    sum       = {1'b0, in0} + {1'b0, in1};
    diff      = in0 - in1;
    shl_w     = {1'b0, in0} << in1;
    shr_w     = {in0, 1'b0} >> in1;
    nx_result = '0;
    nx_hi     = '0;
    nx_carry  = 1'b0;
    nx_ovf    = OVF_NONE;
    nx_err    = 1'b0;
    nx_iter   = 1'b0;
    nx_div    = 1'b0;
    case (op)
      OPW'(OP_ADD): begin
        nx_result = sum[WIDTH-1:0];
        nx_carry  = sum[WIDTH];
        if (!in0[WIDTH-1] && !in1[WIDTH-1] && sum[WIDTH-1])     nx_ovf = OVF_POS;
        else if (in0[WIDTH-1] && in1[WIDTH-1] && !sum[WIDTH-1]) nx_ovf = OVF_NEG;
      end
      OPW'(OP_SUB): begin
        nx_result = diff;
        nx_carry  = (in0 < in1);
        if (!in0[WIDTH-1] && in1[WIDTH-1] && diff[WIDTH-1])      nx_ovf = OVF_POS;
        else if (in0[WIDTH-1] && !in1[WIDTH-1] && !diff[WIDTH-1]) nx_ovf = OVF_NEG;
      end
      OPW'(OP_FTST): nx_result = diff;
      OPW'(OP_AND):  nx_result = in0 & in1;
      OPW'(OP_OR):   nx_result = in0 | in1;
      OPW'(OP_NOR):  nx_result = ~(in0 | in1);
      OPW'(OP_SLT):  nx_result = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      // the extra bit of each shift vector catches the last bit shifted out
      OPW'(OP_SHL): begin
        nx_result = shl_w[WIDTH-1:0];
        nx_carry  = shl_w[WIDTH];
      end
      OPW'(OP_SHR): begin
        nx_result = shr_w[WIDTH:1];
        nx_carry  = shr_w[0];
      end
      OPW'(OP_MUL): nx_iter = 1'b1;
`ifdef NR_SEQ_ALU_DIV_EN
      OPW'(OP_DIV), OPW'(OP_REM): begin
        if (in1 == '0) begin
          nx_result = '1;
          nx_hi     = in0;
          nx_err    = 1'b1;
        end else begin
          nx_iter = 1'b1;
          nx_div  = 1'b1;
        end
      end
`endif
      default: nx_err = 1'b1;
    endcase
    nx_zero = (op == OPW'(OP_FTST)) ? (((in0 & in1) == in1) && (in0 != '0))
                                    : (nx_result == '0);
  end

  nr_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef NR_SEQ_ALU_DIV_EN
    .div   (nx_div),
`endif
    .a     (in0),
    .b     (in1),
    .nx_hi (md_hi),
    .nx_lo (md_lo),
    .last  (md_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy_div  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      u_zero    <= 1'b0;
      carry     <= 1'b0;
      ovrflw    <= OVF_NONE;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (nx_iter) begin
              state    <= S_BUSY;
              busy_div <= nx_div;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= nx_result;
              result_hi <= nx_hi;
              u_zero    <= nx_zero;
              carry     <= nx_carry;
              ovrflw    <= nx_ovf;
              neg       <= nx_result[WIDTH-1];
              err       <= nx_err;
            end
          end
        end
        S_BUSY: begin
          if (md_last) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= md_lo;
            result_hi <= md_hi;
            u_zero    <= (md_lo == '0);
            carry     <= !busy_div && (md_hi != '0);
            ovrflw    <= OVF_NONE;
            neg       <= md_lo[WIDTH-1];
            err       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_seq_alu.sv
// Self-checking bench for nr_seq_alu (WIDTH=8): reference model feeds an expected-result queue.
module tb_nr_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op;
  logic [7:0] in0, in1, result, result_hi;
  logic       u_zero, carry, neg, err;
  logic [1:0] ovrflw;

  logic [21:0] exp_q[$];
  int          lat_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  nr_seq_alu #(.WIDTH(8), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .u_zero(u_zero), .carry(carry),
    .ovrflw(ovrflw), .neg(neg), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected bundle: {err, ovrflw[1:0], neg, carry, u_zero, result_hi[7:0], result[7:0]}
  function automatic logic [21:0] model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  r, h;
    logic        c, z, e;
    logic [1:0]  v;
    logic [8:0]  s;
    logic [15:0] p;
    int          sa, sb, d, t;
    r = 8'h00; h = 8'h00; c = 1'b0; e = 1'b0; v = 2'b00;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (o)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        d = sa + sb;
        v = (d > 127) ? 2'b01 : (d < -128) ? 2'b10 : 2'b00;
      end
      4'd1: begin
        r = a - b; c = (a < b);
        d = sa - sb;
        v = (d > 127) ? 2'b01 : (d < -128) ? 2'b10 : 2'b00;
      end
      4'd2: r = a - b;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = ~(a | b);
      4'd6: r = (sa < sb) ? 8'd1 : 8'd0;
      4'd7: begin
        t = int'(a) << b;
        r = t[7:0]; c = t[8];
      end
      4'd8: begin
        t = (int'(a) << 1) >> b;
        r = t[8:1]; c = t[0];
      end
      4'd9: begin
        p = 16'(a) * 16'(b);
        r = p[7:0]; h = p[15:8]; c = (h != 8'h00);
      end
`ifdef NR_SEQ_ALU_DIV_EN
      4'd10, 4'd11: begin
        if (b == 8'h00) begin
          r = 8'hFF; h = a; e = 1'b1;
        end else begin
          r = a / b; h = a % b;
        end
      end
`endif
      default: e = 1'b1;
    endcase
    z = (o == 4'd2) ? (((a & b) == b) && (a != 8'h00)) : (r == 8'h00);
    return {e, v, r[7], c, z, h, r};
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [7:0] b);
    logic div_en;
    div_en = 1'b0;
`ifdef NR_SEQ_ALU_DIV_EN
    div_en = 1'b1;
`endif
    if (o == 4'd9) return 9;
    if (div_en && (o == 4'd10 || o == 4'd11) && b != 8'h00) return 9;
    return 1;
  endfunction

  function automatic logic [21:0] dut_bundle();
    return {err, ovrflw, neg, carry, u_zero, result_hi, result};
  endfunction

  task automatic check_bundle(input logic [3:0] o, input logic [21:0] e);
    check($sformatf("result op%0d", o),    32'(result),    32'(e[7:0]));
    check($sformatf("result_hi op%0d", o), 32'(result_hi), 32'(e[15:8]));
    check($sformatf("u_zero op%0d", o),    32'(u_zero),    32'(e[16]));
    check($sformatf("carry op%0d", o),     32'(carry),     32'(e[17]));
    check($sformatf("neg op%0d", o),       32'(neg),       32'(e[18]));
    check($sformatf("ovrflw op%0d", o),    32'(ovrflw),    32'(e[20:19]));
    check($sformatf("err op%0d", o),       32'(err),       32'(e[21]));
  endtask

  // driver: one request, stray requests while busy, optional backpressure, then retire
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [21:0] e;
    int          lat, n;
    exp_q.push_back(model(o, a, b));
    lat_q.push_back(model_lat(o, b));
    @(negedge clk);
    in_valid = 1'b1; op = o; in0 = a; in1 = b; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    lat = 1;
    op  = 4'($urandom_range(0, 15));
    in0 = 8'($urandom);
    in1 = 8'($urandom);
    while (!out_valid && lat < 40) begin
      check("busy in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("latency op%0d", o), 32'(lat), 32'(lat_q.pop_front()));
    check_bundle(o, e);
    repeat (hold) begin
      @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold outputs", 32'(dut_bundle()), 32'(e));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready after retire", 32'(in_ready), 32'd1);
    check("out_valid after retire", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; in0 = 8'h00; in1 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset outputs", 32'(dut_bundle()), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    run_op(4'd0, 8'h70, 8'h20, 0);
    run_op(4'd0, 8'hFF, 8'h01, 0);
    run_op(4'd1, 8'h80, 8'h01, 0);
    run_op(4'd1, 8'h03, 8'h05, 0);
    run_op(4'd9, 8'hFF, 8'hFF, 0);

    // reset in the middle of a multiply: the operation is dropped without a result
    @(negedge clk);
    in_valid = 1'b1; op = 4'd9; in0 = 8'hFF; in1 = 8'hFF;
    check("mul accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst outputs", 32'(dut_bundle()), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst release in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("midrst abandoned", 32'(out_valid), 32'd0);

    run_op(4'd2, 8'h0F, 8'h05, 0);
    run_op(4'd7, 8'h81, 8'h01, 5);
    run_op(4'd8, 8'hA5, 8'h09, 0);
    run_op(4'd8, 8'h81, 8'h08, 0);
    run_op(4'd7, 8'h01, 8'h08, 0);
    run_op(4'd3, 8'hF0, 8'h3C, 0);
    run_op(4'd4, 8'hF0, 8'h0C, 0);
    run_op(4'd5, 8'hF0, 8'h0C, 0);
    run_op(4'd6, 8'h80, 8'h01, 0);
    run_op(4'd6, 8'h01, 8'h80, 0);
    run_op(4'd2, 8'h00, 8'h00, 0);
    run_op(4'd10, 8'd200, 8'd7, 0);
    run_op(4'd11, 8'h55, 8'h00, 0);
    run_op(4'd13, 8'h12, 8'h34, 2);
    run_op(4'd9, 8'h00, 8'h37, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 2)));
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nr_seq_alu.md
Name: nr_seq_alu

Overview:
- Parametrised, registered successor to the processor's combinational 8-bit ALU.
- Adds a valid/ready handshake, an output result register, signed overflow and carry flags, and an iterative shift-add multiplier.
- Adds an optional iterative restoring divider.
- Sits between the register-file read stage and write-back; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- OPW, 4, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  OPW  opcode.
- in0  in  WIDTH  operand A.
- in1  in  WIDTH  operand B.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  low result / quotient.
- result_hi  out  WIDTH  MUL high half / DIV-REM remainder; 0 for other ops.
- u_zero  out  1  zero/condition flag.
- carry  out  1  unsigned carry/borrow.
- ovrflw  out  2  signed overflow: 01 positive, 10 negative, 00 none.
- neg  out  1  result MSB.
- err  out  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs go to 0, except in_ready, which is 1 once rst deasserts.
  - Any in-flight operation is abandoned with no output.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). A handshake occurs on in_valid&&in_ready at a rising edge; operands and op are latched at that edge.
- Single-cycle ops:
  - ADD=0: {carry,result}=in0+in1. ovrflw=01 if both operands are non-negative and the result is negative; 10 if both are negative and the result is non-negative. Result wraps modulo 2^WIDTH with no saturation.
  - SUB=1: result=in0-in1; carry=borrow (in0<in1 unsigned). Signed overflow uses the same 01/10 encoding.
  - FTST=2: u_zero=((in0&in1)==in1)&&(in0!=0); result=in0-in1.
  - AND=3, OR=4, NOR=5: bitwise.
  - SLT=6: result=1 if in0<in1 signed, else 0.
  - SHL=7, SHR=8: logical shift by the unsigned value of in1; in1>=WIDTH gives 0; carry = last bit shifted out.
  - Path: IDLE -> DONE; out_valid rises 1 cycle after the handshake.
- For every op except FTST, u_zero = (result==0).
- MUL=9 (unsigned):
  - IDLE -> BUSY; counter loads WIDTH.
  - Each cycle performs one shift-add step.
  - BUSY -> DONE when the counter reaches 0, giving out_valid WIDTH+1 cycles after the handshake.
  - {result_hi,result} = full 2*WIDTH-bit product. carry = (result_hi!=0).
- DIV=10 / REM=11: only with the optional divider (see Optional Feature).
- Opcodes 12..15, and 10/11 without the divider: result=0, err=1, 1-cycle latency.
- DONE: outputs are held stable while out_valid=1 && out_ready=0. On out_ready, DONE -> IDLE; the next request is accepted on the following edge, so there is no same-cycle accept.
- Outputs change only on the DONE entry edge.
- in_valid is ignored while BUSY or DONE; the requester must hold the request.

Optional Feature:
- Macro: NR_SEQ_ALU_DIV_EN.
- Defined: DIV/REM use an unsigned restoring divider with the same WIDTH+1 latency as MUL.
  - result = quotient, result_hi = remainder.
  - Divide by zero takes 1 cycle: result=all ones, result_hi=in0, err=1.
- Undefined: the divider logic is absent; ops 10/11 are handled as illegal.

Decomposition:
- Package nr_alu_pkg holds:
  - opcode localparams ADD..REM;
  - FSM state encoding;
  - ovrflw codes OVF_NONE=00, OVF_POS=01, OVF_NEG=10.
- One sub-module: nr_iter_muldiv, holding the shared WIDTH-step shift register and counter for MUL and, when enabled, DIV. The top level holds the FSM, the single-cycle datapath and the flags.

Test Plan (WIDTH=8):
- ADD 0x70+0x20 -> result=0x90, ovrflw=01, carry=0, neg=1. ADD 0xFF+0x01 -> result=0x00, u_zero=1, carry=1, ovrflw=00. Both complete with out_valid 1 cycle after the handshake.
- SUB 0x80-0x01 -> result=0x7F, ovrflw=10. SUB 0x03-0x05 -> result=0xFE, carry=1.
- MUL 0xFF*0xFF -> result_hi=0xFE, result=0x01, carry=1, out_valid exactly 9 cycles after the handshake. in_ready=0 and in_valid is ignored throughout BUSY.
- Backpressure: hold out_ready=0 for 5 cycles after SHL 0x81<<1 -> result=0x02, carry=1 held stable. in_ready rises the cycle after out_ready=1. SHR by 9 -> result=0.
- Assert rst mid-MUL (cycle 4) -> all outputs 0 immediately; after release, FTST in0=0x0F, in1=0x05 -> u_zero=1, result=0x0A.
- With NR_SEQ_ALU_DIV_EN, DIV 200/7 -> result=28, result_hi=4 after 9 cycles; DIV x/0 -> err=1, result=0xFF in 1 cycle. Without the macro, op 10 -> err=1, result=0.
